// File: rtl/dmac_ch0_engine_pkg.sv
// Shared definitions for the DMAC channel 0 transfer engine: AHB encodings,
// Control register field positions, FSM state encoding and address-phase payload.
package dmac_ch0_engine_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 12;

  // AHB encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // DMAC_C0_Control field positions; size occupies [CNT_W-1:0]
  localparam int unsigned CTRL_SI  = 12;
  localparam int unsigned CTRL_DI  = 13;
  localparam int unsigned CTRL_TCI = 14;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD_A,
    ST_RD_D,
    ST_WR_A,
    ST_WR_D,
    ST_DONE,
    ST_ERR,
    ST_ABORT
  } state_e;

  // AHB master address-phase payload
  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
  } ahb_aph_t;

  // Force an address onto a word boundary
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmac_ch0_engine_addr_cnt.sv
// dmac_addr_cnt: source/destination address and remaining-count registers.
// Ports: clk/rst_n; load captures programmed values and SI/DI; step completes
// one word (count down, optional +4 address increments, wrapping mod 2^32).
// cnt is registered; src_nxt_c/dst_nxt_c expose the next-cycle addresses so
// the top can register its address-phase outputs in step with these flops.
module dmac_addr_cnt
  import dmac_ch0_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              si_in,
  input  logic              di_in,
  output logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] src_nxt_c,
  output logic [ADDR_W-1:0] dst_nxt_c
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              si_q, si_d;
  logic              di_q, di_d;

  // Load on start, update on each completed word
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    si_d  = si_q;
    di_d  = di_q;
    if (load) begin
      src_d = word_align(src_in);
      dst_d = word_align(dst_in);
      cnt_d = cnt_in;
      si_d  = si_in;
      di_d  = di_in;
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (si_q) src_d = src_q + ADDR_W'(4);
      if (di_q) dst_d = dst_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      si_q  <= 1'b0;
      di_q  <= 1'b0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
      si_q  <= si_d;
      di_q  <= di_d;
    end
  end

  assign cnt       = cnt_q;
  assign src_nxt_c = src_d;
  assign dst_nxt_c = dst_d;

endmodule

// File: rtl/dmac_ch0_engine.sv
// DMAC channel 0 transfer engine: moves one word per iteration with an AHB
// single read followed by an AHB single write until the count is exhausted.
// Inputs: channel programming from the register bank, AHB grant/ready/resp/rdata.
// Outputs: AHB master request/address/control/wdata (all registered),
// ch_active, tc_pulse, err_pulse status pulses and remain_cnt.
module dmac_ch0_engine
  import dmac_ch0_engine_pkg::*;
(
  input  logic              s_HCLK,
  input  logic              s_HRESETn,
  input  logic [31:0]       DMAC_Configuration,
  input  logic [ADDR_W-1:0] DMAC_C0_SrcAddr,
  input  logic [ADDR_W-1:0] DMAC_C0_DestAddr,
  input  logic [31:0]       DMAC_C0_Control,
  input  logic              DMAC_C0_Configuration,
  input  logic              m_HGRANT,
  input  logic              m_HREADY,
  input  logic [1:0]        m_HRESP,
  input  logic [DATA_W-1:0] m_HRDATA,
  output logic              m_HBUSREQ,
  output logic [ADDR_W-1:0] m_HADDR,
  output logic [1:0]        m_HTRANS,
  output logic              m_HWRITE,
  output logic [2:0]        m_HSIZE,
  output logic [2:0]        m_HBURST,
  output logic [DATA_W-1:0] m_HWDATA,
  output logic              ch_active,
  output logic              tc_pulse,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  remain_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  ahb_aph_t          aph_q, aph_d;
  logic              hbusreq_q, hbusreq_d;
  logic              ch_active_q, ch_active_d;
  logic              tc_q, tc_d;
  logic              err_q, err_d;

  logic              enable_c, start_c, hresp_err_c;
  logic              load_c, step_c;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] src_nxt_c, dst_nxt_c;
  logic              unused_c;

  assign enable_c    = DMAC_Configuration[0] & DMAC_C0_Configuration;
  assign start_c     = enable_c & (DMAC_C0_Control[CNT_W-1:0] != '0);
  assign hresp_err_c = (m_HRESP == HRESP_ERROR);
  // TC interrupt enable is consumed by the register bank, not here
  assign unused_c    = ^{DMAC_Configuration[31:1], DMAC_C0_Control[31:CTRL_DI+1]};

  dmac_addr_cnt u_addr_cnt (
    .clk       (s_HCLK),
    .rst_n     (s_HRESETn),
    .load      (load_c),
    .step      (step_c),
    .src_in    (DMAC_C0_SrcAddr),
    .dst_in    (DMAC_C0_DestAddr),
    .cnt_in    (DMAC_C0_Control[CNT_W-1:0]),
    .si_in     (DMAC_C0_Control[CTRL_SI]),
    .di_in     (DMAC_C0_Control[CTRL_DI]),
    .cnt       (cnt),
    .src_nxt_c (src_nxt_c),
    .dst_nxt_c (dst_nxt_c)
  );

  // Next-state logic and data capture
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          load_c  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_HGRANT && m_HREADY) state_d = ST_RD_A;
      end
      ST_RD_A: begin
        if (m_HREADY) state_d = ST_RD_D;
      end
      ST_RD_D: begin
        // ERROR is taken on the first (HREADY low) cycle of the response
        if (hresp_err_c) begin
          state_d = ST_ERR;
        end else if (m_HREADY) begin
          buf_d   = m_HRDATA;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A: begin
        if (m_HREADY) state_d = ST_WR_D;
      end
      ST_WR_D: begin
        if (hresp_err_c) begin
          state_d = ST_ERR;
        end else if (m_HREADY) begin
          step_c = 1'b1;
          // Enable is only sampled here, so an in-flight word always finishes
          if (cnt == CNT_W'(1))  state_d = ST_DONE;
          else if (!enable_c)    state_d = ST_ABORT;
          else if (m_HGRANT)     state_d = ST_RD_A;
          else                   state_d = ST_REQ;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from next state so every output leaves a flop
  always_comb begin
    aph_d        = aph_q;
    aph_d.htrans = HTRANS_IDLE;
    aph_d.hwrite = 1'b0;
    if (state_d == ST_RD_A) begin
      aph_d.haddr  = src_nxt_c;
      aph_d.htrans = HTRANS_NONSEQ;
    end else if (state_d == ST_WR_A) begin
      aph_d.haddr  = dst_nxt_c;
      aph_d.htrans = HTRANS_NONSEQ;
      aph_d.hwrite = 1'b1;
    end
    hbusreq_d   = (state_d == ST_REQ)  || (state_d == ST_RD_A) || (state_d == ST_RD_D) ||
                  (state_d == ST_WR_A) || (state_d == ST_WR_D);
    ch_active_d = (state_d != ST_IDLE);
    tc_d        = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge s_HCLK or negedge s_HRESETn) begin
    if (!s_HRESETn) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      aph_q       <= '0;
      hbusreq_q   <= 1'b0;
      ch_active_q <= 1'b0;
      tc_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      aph_q       <= aph_d;
      hbusreq_q   <= hbusreq_d;
      ch_active_q <= ch_active_d;
      tc_q        <= tc_d;
      err_q       <= err_d;
    end
  end

  assign m_HBUSREQ  = hbusreq_q;
  assign m_HADDR    = aph_q.haddr;
  assign m_HTRANS   = aph_q.htrans;
  assign m_HWRITE   = aph_q.hwrite;
  assign m_HSIZE    = HSIZE_WORD;
  assign m_HBURST   = HBURST_SINGLE;
  // buf only changes at read completion, so it is stable through WR_D waits
  assign m_HWDATA   = buf_q;
  assign ch_active  = ch_active_q;
  assign tc_pulse   = tc_q;
  assign err_pulse  = err_q;
  assign remain_cnt = cnt;

endmodule

// File: tb/tb_dmac_ch0_engine.sv
// Directed bench for dmac_ch0_engine with an AHB slave/memory model and a
// register-bank stand-in that clears the channel enable on tc/err pulses.
`timescale 1ns/1ps
module tb_dmac_ch0_engine;
  import dmac_ch0_engine_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_r, src_r, dst_r, ctrl_r;
  logic        c0_sw, c0_en;
  logic        grant, hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        m_HBUSREQ, m_HWRITE, ch_active, tc_pulse, err_pulse;
  logic [31:0] m_HADDR, m_HWDATA;
  logic [1:0]  m_HTRANS;
  logic [2:0]  m_HSIZE, m_HBURST;
  logic [11:0] remain_cnt;

  int n_cmp, n_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmac_ch0_engine dut (
    .s_HCLK(clk), .s_HRESETn(rst_n),
    .DMAC_Configuration(cfg_r), .DMAC_C0_SrcAddr(src_r), .DMAC_C0_DestAddr(dst_r),
    .DMAC_C0_Control(ctrl_r), .DMAC_C0_Configuration(c0_en),
    .m_HGRANT(grant), .m_HREADY(hready), .m_HRESP(hresp), .m_HRDATA(hrdata),
    .m_HBUSREQ(m_HBUSREQ), .m_HADDR(m_HADDR), .m_HTRANS(m_HTRANS), .m_HWRITE(m_HWRITE),
    .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HWDATA(m_HWDATA),
    .ch_active(ch_active), .tc_pulse(tc_pulse), .err_pulse(err_pulse), .remain_cnt(remain_cnt)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Register-bank stand-in: any tc/err pulse clears the channel enable
  int cyc, tc_total, err_total, done_snap;
  always @(negedge clk) begin
    cyc++;
    if (tc_pulse === 1'b1)  tc_total++;
    if (err_pulse === 1'b1) err_total++;
  end
  assign c0_en = c0_sw && ((tc_total + err_total) == done_snap);

  // AHB slave model: responses driven 1ns after each rising edge
  logic [1:0]  pa_trans;
  logic [31:0] pa_addr, pa_wdata;
  logic        pa_write;
  logic        dph_act, dph_wr, dph_err;
  logic [31:0] dph_addr;
  int          wait_left, err_stage;
  int          rd_waits, err_at;
  logic [31:0] obs_raddr[$], obs_waddr[$], obs_wdata[$], obs_wait[$];

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      dph_act = 1'b0; hready = 1'b1; hresp = HRESP_OKAY; hrdata = '0;
      pa_trans = HTRANS_IDLE; pa_addr = '0; pa_write = 1'b0; pa_wdata = '0;
    end else begin
      if (dph_act && hready) begin
        if (dph_wr) begin
          obs_waddr.push_back(dph_addr);
          obs_wdata.push_back(pa_wdata);
        end
        dph_act = 1'b0;
      end
      if (pa_trans == HTRANS_NONSEQ && hready) begin
        dph_act = 1'b1; dph_addr = pa_addr; dph_wr = pa_write;
        dph_err = 1'b0; wait_left = 0; err_stage = 0;
        if (!pa_write) begin
          obs_raddr.push_back(pa_addr);
          wait_left = rd_waits;
          dph_err = (obs_raddr.size() == err_at);
        end
      end
      hready = 1'b1; hresp = HRESP_OKAY; hrdata = '0;
      if (dph_act) begin
        if (dph_err) begin
          hresp = HRESP_ERROR; hready = (err_stage == 1); err_stage++;
        end else if (wait_left > 0) begin
          hready = 1'b0; wait_left--;
          obs_wait.push_back(m_HADDR);
        end else if (!dph_wr) begin
          hrdata = mem_data(dph_addr);
        end
      end
      pa_trans = m_HTRANS; pa_addr = m_HADDR; pa_write = m_HWRITE; pa_wdata = m_HWDATA;
    end
  end

  // Scoreboard: expectations queued at stimulus time, popped against observations
  logic [31:0] exp_raddr[$], exp_waddr[$], exp_wdata[$], exp_wait[$];
  int rd_k, wr_k, wt_k, tc_snap, err_snap;

  task automatic exp_word(input logic [31:0] ra, input logic [31:0] wa);
    exp_raddr.push_back(ra);
    exp_waddr.push_back(wa);
    exp_wdata.push_back(mem_data(ra));
  endtask

  task automatic drain_sb(input string tag);
    logic [31:0] e;
    chk({tag, "_rd_n"}, 32'(obs_raddr.size() - rd_k), 32'(exp_raddr.size()));
    chk({tag, "_wr_n"}, 32'(obs_waddr.size() - wr_k), 32'(exp_waddr.size()));
    chk({tag, "_wait_n"}, 32'(obs_wait.size() - wt_k), 32'(exp_wait.size()));
    while (exp_raddr.size() > 0) begin
      e = exp_raddr.pop_front();
      if (rd_k < obs_raddr.size()) begin chk({tag, "_rd_addr"}, obs_raddr[rd_k], e); rd_k++; end
    end
    while (exp_waddr.size() > 0) begin
      e = exp_waddr.pop_front();
      if (wr_k < obs_waddr.size()) begin
        chk({tag, "_wr_addr"}, obs_waddr[wr_k], e);
        e = exp_wdata.pop_front();
        chk({tag, "_wr_data"}, obs_wdata[wr_k], e);
        wr_k++;
      end
    end
    exp_wdata.delete();
    while (exp_wait.size() > 0) begin
      e = exp_wait.pop_front();
      if (wt_k < obs_wait.size()) begin chk({tag, "_wait_haddr"}, obs_wait[wt_k], e); wt_k++; end
    end
    rd_k = obs_raddr.size(); wr_k = obs_waddr.size(); wt_k = obs_wait.size();
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int unsigned size,
                            input logic si, input logic di);
    src_r  = s;
    dst_r  = d;
    ctrl_r = 32'(size) | (32'(si) << CTRL_SI) | (32'(di) << CTRL_DI) | (32'h1 << CTRL_TCI);
    done_snap = tc_total + err_total;
    tc_snap = tc_total; err_snap = err_total;
    cfg_r = 32'h1; c0_sw = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (ch_active === 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, 32'(ch_active), 32'h0);
  endtask

  task automatic wait_aph(input string tag, input logic wr);
    int n = 0;
    while (!(m_HTRANS === HTRANS_NONSEQ && m_HWRITE === wr) && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_aph_seen"}, 32'(m_HTRANS), 32'(HTRANS_NONSEQ));
  endtask

  initial begin
    int n;
    watchdog_arm();
    rst_n = 1'b0; cfg_r = '0; src_r = '0; dst_r = '0; ctrl_r = '0; c0_sw = 1'b0;
    grant = 1'b1; rd_waits = 0; err_at = 0; done_snap = 0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_hbusreq", 32'(m_HBUSREQ), 0);
    chk("rst_haddr", m_HADDR, 0);
    chk("rst_htrans", 32'(m_HTRANS), 32'(HTRANS_IDLE));
    chk("rst_hwrite", 32'(m_HWRITE), 0);
    chk("rst_hwdata", m_HWDATA, 0);
    chk("rst_hsize", 32'(m_HSIZE), 32'h2);
    chk("rst_hburst", 32'(m_HBURST), 32'h0);
    chk("rst_active", 32'(ch_active), 0);
    chk("rst_pulses", {30'd0, tc_pulse, err_pulse}, 0);
    chk("rst_remain", 32'(remain_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Size 0 start is ignored
    start_xfer(32'h1000, 32'h2000, 0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("zero_active", 32'(ch_active), 0);
    chk("zero_tc", 32'(tc_total - tc_snap), 0);
    c0_sw = 1'b0;

    // T1: 3 words, both increment, zero wait
    exp_word(32'h1000, 32'h2000); exp_word(32'h1004, 32'h2004); exp_word(32'h1008, 32'h2008);
    start_xfer(32'h1000, 32'h2000, 3, 1'b1, 1'b1);
    chk("t1_active", 32'(ch_active), 1);
    wait_aph("t1_rd", 1'b0);
    n = 0;
    while (tc_pulse !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("t1_latency", 32'(n), 12);
    wait_done("t1");
    drain_sb("t1");
    chk("t1_tc", 32'(tc_total - tc_snap), 1);
    chk("t1_err", 32'(err_total - err_snap), 0);
    chk("t1_remain", 32'(remain_cnt), 0);
    chk("t1_busreq", 32'(m_HBUSREQ), 0);

    // T2: peripheral destination, two wait states on each read
    rd_waits = 2;
    exp_word(32'h1000, 32'h2000); exp_word(32'h1004, 32'h2000);
    exp_wait.push_back(32'h1000); exp_wait.push_back(32'h1000);
    exp_wait.push_back(32'h1004); exp_wait.push_back(32'h1004);
    start_xfer(32'h1000, 32'h2000, 2, 1'b1, 1'b0);
    wait_done("t2");
    rd_waits = 0;
    drain_sb("t2");
    chk("t2_tc", 32'(tc_total - tc_snap), 1);

    // T3: ERROR on second read
    err_at = obs_raddr.size() + 2;
    exp_word(32'h4000, 32'h5000); exp_raddr.push_back(32'h4004);
    start_xfer(32'h4000, 32'h5000, 3, 1'b1, 1'b1);
    wait_done("t3");
    err_at = 0;
    drain_sb("t3");
    chk("t3_err", 32'(err_total - err_snap), 1);
    chk("t3_tc", 32'(tc_total - tc_snap), 0);
    chk("t3_remain", 32'(remain_cnt), 2);
    chk("t3_busreq", 32'(m_HBUSREQ), 0);

    // T4: enable cleared during word 1 of 4
    exp_word(32'h6000, 32'h7000);
    start_xfer(32'h6000, 32'h7000, 4, 1'b1, 1'b1);
    wait_aph("t4_rd", 1'b0);
    c0_sw = 1'b0;
    wait_done("t4");
    drain_sb("t4");
    chk("t4_pulses", 32'((tc_total - tc_snap) + (err_total - err_snap)), 0);
    chk("t4_remain", 32'(remain_cnt), 3);

    // T5: grant withheld in REQ and between words
    grant = 1'b0;
    exp_word(32'h8000, 32'h9000); exp_word(32'h8004, 32'h9004);
    start_xfer(32'h8000, 32'h9000, 2, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_req_htrans", 32'(m_HTRANS), 32'(HTRANS_IDLE));
      chk("t5_req_busreq", 32'(m_HBUSREQ), 1);
      @(negedge clk);
    end
    grant = 1'b1;
    wait_aph("t5_wr", 1'b1);
    grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_gap_htrans", 32'(m_HTRANS), 32'(HTRANS_IDLE));
    end
    grant = 1'b1;
    wait_done("t5");
    drain_sb("t5");
    chk("t5_tc", 32'(tc_total - tc_snap), 1);

    // T6: source address wraps past 0xFFFFFFFC
    exp_word(32'hFFFF_FFFC, 32'hA000); exp_word(32'h0000_0000, 32'hA004);
    start_xfer(32'hFFFF_FFFC, 32'hA000, 2, 1'b1, 1'b1);
    wait_done("t6");
    drain_sb("t6");
    chk("t6_tc", 32'(tc_total - tc_snap), 1);

    // T7: asynchronous reset in WR_D of word 1
    exp_raddr.push_back(32'hB000);
    start_xfer(32'hB000, 32'hC000, 2, 1'b1, 1'b1);
    wait_aph("t7_wr", 1'b1);
    @(negedge clk);
    rst_n = 1'b0; c0_sw = 1'b0;
    #1;
    chk("t7_busreq", 32'(m_HBUSREQ), 0);
    chk("t7_haddr", m_HADDR, 0);
    chk("t7_htrans", 32'(m_HTRANS), 32'(HTRANS_IDLE));
    chk("t7_hwdata", m_HWDATA, 0);
    chk("t7_active", 32'(ch_active), 0);
    chk("t7_remain", 32'(remain_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drain_sb("t7");
    chk("t7_pulses", 32'((tc_total - tc_snap) + (err_total - err_snap)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  task automatic watchdog_arm();
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
    join_none
  endtask

endmodule
